// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ producers.
// All outputs are registered; pushes are withheld whenever the FIFO could overflow.
module fifo_push_arbiter #(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [$clog2(DEPTH):0]     item_count,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       push_enable,
  output logic [WIDTH-1:0]           push_data,
  output logic                       stall
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]          r_last;
  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_space;
  logic [2*NUM_REQ-1:0]   w_dbl;
  logic [IW-1:0]          w_off;
  logic [IW-1:0]          w_win;
  logic                   w_found;
  int                     w_sum;

  assign w_elig  = req & ~grant;
  // One extra bit so item_count + in-flight push cannot wrap.
  assign w_space = ({1'b0, item_count} + {{CW{1'b0}}, push_enable}) < (CW+1)'(DEPTH);

  // Rotate the eligible set so bit 0 is the requester just after r_last,
  // then take the lowest set bit and rotate the index back.
  always_comb begin
    w_dbl   = {w_elig, w_elig} >> (int'(r_last) + 1);
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_dbl[k]) begin
        w_found = 1'b1;
        w_off   = IW'(k);
      end
    end
    w_sum = int'(r_last) + 1 + int'(w_off);
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
    w_win = IW'(w_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= IW'(NUM_REQ - 1);
      grant       <= '0;
      push_enable <= 1'b0;
      push_data   <= '0;
      stall       <= 1'b0;
    end else if (w_found && w_space) begin
      r_last      <= w_win;
      grant       <= NUM_REQ'(1) << w_win;
      push_enable <= 1'b1;
      push_data   <= req_data[w_win*WIDTH +: WIDTH];
      stall       <= 1'b0;
    end else begin
      grant       <= '0;
      push_enable <= 1'b0;
      stall       <= w_found;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed and random checks of fifo_push_arbiter against a cycle model
// built from the arbitration rules, with a queue-based FIFO attached.
module tb_fifo_push_arbiter;
  localparam int W  = 2;
  localparam int D  = 4;
  localparam int N  = 4;
  localparam int CW = $clog2(D) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [CW-1:0]    item_count = '0;
  logic [N-1:0]     grant;
  logic             push_enable;
  logic [W-1:0]     push_data;
  logic             stall;

  fifo_push_arbiter #(.WIDTH(W), .DEPTH(D), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .item_count(item_count), .grant(grant), .push_enable(push_enable),
    .push_data(push_data), .stall(stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int           m_last;
  logic [N-1:0] m_grant;
  logic         m_pe;
  logic [W-1:0] m_pd;
  logic         m_st;
  logic [W-1:0] mq[$];   // items the model says were pushed, in order

  // attached FIFO fed by the DUT outputs
  logic [W-1:0] fq[$];
  logic         s_pe;
  logic [W-1:0] s_pd;
  bit           ov_en;
  int           ov_val;
  bit           pop;

  // producers
  int           rem[N];
  logic [W-1:0] pdat[N];
  bit           auto_prod;
  bit           inc_mode;
  bit           rnd_start;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pdat[i];
  endtask

  task automatic model_reset();
    m_last = N - 1; m_grant = '0; m_pe = 1'b0; m_pd = '0; m_st = 1'b0;
    mq.delete(); fq.delete();
    s_pe = 1'b0; s_pd = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; pop = 1'b0; ov_en = 1'b0; auto_prod = 1'b0; inc_mode = 1'b0; rnd_start = 1'b0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; pdat[i] = '0; end
    drive_data();
    item_count = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_count(input int v);
    ov_en = 1'b1; ov_val = v; item_count = CW'(v);
  endtask

  task automatic tick();
    logic [N-1:0] elig;
    bit           space;
    int           win;
    logic [W-1:0] v;
    @(posedge clk);
    // arbitration rules applied to the values present before this edge
    elig  = req & ~m_grant;
    space = (int'(item_count) + int'(m_pe)) < D;
    if (elig != 0 && space) begin
      win = -1;
      for (int off = 1; off <= N; off++)
        if (win < 0 && elig[(m_last + off) % N]) win = (m_last + off) % N;
      m_grant = '0; m_grant[win] = 1'b1;
      m_pe = 1'b1; m_pd = req_data[win*W +: W]; m_last = win; m_st = 1'b0;
      mq.push_back(m_pd);
    end else begin
      m_grant = '0; m_pe = 1'b0; m_st = (elig != 0);
    end
    // FIFO: pop first, then absorb the push that was in flight
    if (pop && fq.size() > 0) begin
      v = fq.pop_front();
      if (mq.size() > 0) chk("pop_order", 32'(v), 32'(mq.pop_front()));
    end
    if (s_pe) begin
      if (!ov_en) chk("no_overflow", 32'(fq.size() < D), 32'd1);
      if (fq.size() < D) fq.push_back(s_pd);
    end
    #1;
    chk("grant", 32'(grant), 32'(m_grant));
    chk("push_enable", 32'(push_enable), 32'(m_pe));
    chk("push_data", 32'(push_data), 32'(m_pd));
    chk("stall", 32'(stall), 32'(m_st));
    s_pe = push_enable; s_pd = push_data;
    item_count = ov_en ? CW'(ov_val) : CW'(fq.size());
    if (auto_prod) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i] && rem[i] > 0) begin
          rem[i]--;
          pdat[i] = inc_mode ? pdat[i] + 1'b1 : W'($urandom);
          req[i]  = (rem[i] > 0);
        end else if (rnd_start && rem[i] == 0 && ($urandom % 4) == 0) begin
          rem[i]  = $urandom_range(3, 1);
          pdat[i] = W'($urandom);
          req[i]  = 1'b1;
        end
      end
      drive_data();
    end
  endtask

  initial begin
    // 1: reset, including an asynchronous reset during a grant
    do_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    req = 4'b0001; pdat[0] = 2'b11; drive_data();
    tick();
    chk("t1_pre_grant", 32'(grant), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_grant", 32'(grant), 32'd0);
    chk("t1_async_pe", 32'(push_enable), 32'd0);
    chk("t1_async_pd", 32'(push_data), 32'd0);
    chk("t1_async_stall", 32'(stall), 32'd0);
    do_reset();
    req = 4'b0100; pdat[2] = 2'b10; drive_data();
    tick();
    chk("t1_first_grant", 32'(grant), 32'b0100);

    // 2: single producer holding its request
    do_reset();
    req = 4'b0001; pdat[0] = 2'b01; drive_data();
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("t2_alt", 32'(grant), (t % 2 == 0) ? 32'd1 : 32'd0);
      if (grant[0]) chk("t2_data", 32'(push_data), 32'b01);
    end
    chk("t2_count", 32'(fq.size()), 32'd3);

    // 3: all four at once, each drops after its grant
    do_reset();
    auto_prod = 1'b1;
    for (int i = 0; i < N; i++) begin rem[i] = 1; pdat[i] = W'(i); end
    drive_data(); req = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t3_grant", 32'(grant), 32'd1 << t);
      chk("t3_data", 32'(push_data), 32'(t));
    end
    tick();
    chk("t3_count", 32'(fq.size()), 32'd4);

    // 4: full guard with item_count driven by the bench
    do_reset();
    set_count(3);
    req = 4'b0001; pdat[0] = 2'b10; drive_data();
    tick();
    chk("t4_grant", 32'(grant), 32'd1);
    set_count(4);
    tick(); tick();
    chk("t4_stall", 32'(stall), 32'd1);
    chk("t4_no_push", 32'(push_enable), 32'd0);
    tick();
    chk("t4_stall_hold", 32'(stall), 32'd1);
    set_count(2);
    tick();
    chk("t4_resume", 32'(grant), 32'd1);

    // 5: two producers held continuously alternate without gaps
    do_reset();
    pop = 1'b1;
    pdat[1] = 2'b10; pdat[3] = 2'b11; drive_data(); req = 4'b1010;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("t5_grant", 32'(grant), (t % 2 == 0) ? 32'b0010 : 32'b1000);
      chk("t5_data", 32'(push_data), (t % 2 == 0) ? 32'b10 : 32'b11);
    end

    // 6: fill the FIFO, stall, pop once, then drain in order
    do_reset();
    auto_prod = 1'b1; inc_mode = 1'b1;
    rem[0] = 5; pdat[0] = 2'b00; drive_data(); req = 4'b0001;
    for (int t = 0; t < 10; t++) tick();
    chk("t6_full", 32'(fq.size()), 32'd4);
    chk("t6_stall", 32'(stall), 32'd1);
    pop = 1'b1; tick(); pop = 1'b0;
    tick(); tick(); tick();
    chk("t6_fifth", 32'(fq.size()), 32'd4);
    chk("t6_done", 32'(rem[0]), 32'd0);
    pop = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    chk("t6_drained", 32'(fq.size()), 32'd0);

    // random traffic with random pops
    do_reset();
    auto_prod = 1'b1; rnd_start = 1'b1;
    for (int t = 0; t < 600; t++) begin
      pop = (($urandom % 3) == 0);
      tick();
    end
    rnd_start = 1'b0; pop = 1'b1;
    for (int t = 0; t < 40; t++) tick();
    chk("rnd_drained", 32'(fq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
